// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges pipeline writebacks and multi-cycle-unit results
// onto one register-file write port. MDU results wait in a 2-entry FIFO; a
// starvation counter forces the FIFO head through when the pipeline hogs
// the port for STARVE_LIMIT cycles.
// Optional build macro: WB_STALL_CNT_EN adds the 16-bit stall_cnt output.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [63:0] pipe_data,
  output logic        pipe_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [63:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        pend_rs1,
  output logic        pend_rs2
`ifdef WB_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic {ST_NORM, ST_FORCE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  vld_q, vld_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [4:0]  frd_q   [2];
  logic [63:0] fdata_q [2];
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [63:0] wdata_q, wdata_d;

  logic fifo_full, fifo_empty, push, pop, pipe_xfer;

  assign fifo_full  = &vld_q;
  assign fifo_empty = ~|vld_q;
  assign mdu_ready  = ~fifo_full;
  assign pipe_ready = (state_q == ST_NORM);
  assign push       = mdu_valid & mdu_ready;
  assign pipe_xfer  = pipe_valid & pipe_ready;
  // The head only pops from entries already stored (no pass-through), either
  // when forced or when the pipeline leaves the port free.
  assign pop        = ~fifo_empty & ((state_q == ST_FORCE) | ~pipe_valid);

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

  // Next-state logic: FIFO bookkeeping, starvation counter, FSM and write port.
  always_comb begin
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    cnt_d    = cnt_q;
    state_d  = state_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;

    if (pop)
      cnt_d = 4'd0;
    else if (!fifo_empty && cnt_q != 4'hF)
      cnt_d = cnt_q + 4'd1;

    case (state_q)
      ST_NORM:  if (cnt_d == 4'(STARVE_LIMIT)) state_d = ST_FORCE;
      ST_FORCE: state_d = ST_NORM;
      default:  state_d = ST_NORM;
    endcase

    // Writes to x0 are consumed but never enable the register file.
    if (pipe_xfer) begin
      we_d    = (pipe_rd != 5'd0);
      waddr_d = pipe_rd;
      wdata_d = pipe_data;
    end else if (pop) begin
      we_d    = (frd_q[rd_ptr_q] != 5'd0);
      waddr_d = frd_q[rd_ptr_q];
      wdata_d = fdata_q[rd_ptr_q];
    end
  end

  // State registers; reset empties the FIFO and silences the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_NORM;
      cnt_q    <= 4'd0;
      vld_q    <= 2'b00;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 64'd0;
      for (int i = 0; i < 2; i++) begin
        frd_q[i]   <= 5'd0;
        fdata_q[i] <= 64'd0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      if (push) begin
        frd_q[wr_ptr_q]   <= mdu_rd;
        fdata_q[wr_ptr_q] <= mdu_data;
      end
    end
  end

  // Hazard query: does a nonzero address match any queued MDU destination?
  always_comb begin
    pend_rs1 = 1'b0;
    pend_rs2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (vld_q[i] && frd_q[i] == q_rs1) pend_rs1 = 1'b1;
      if (vld_q[i] && frd_q[i] == q_rs2) pend_rs2 = 1'b1;
    end
    if (q_rs1 == 5'd0) pend_rs1 = 1'b0;
    if (q_rs2 == 5'd0) pend_rs2 = 1'b0;
  end

`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_q;
  assign stall_cnt = stall_q;

  // Saturating count of cycles the pipeline was held off the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= 16'd0;
    else if (pipe_valid && !pipe_ready && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end
`endif

endmodule
